if_fetch: RTL and testbench

Instruction fetch stage directly upstream of the instruction decoder/controller. Owns the program counter, issues word fetches to instruction memory over a request/grant/response handshake with one outstanding access, and presents `{instr, pc, pc+4}` to decode through an IF/ID register backed by a one-entry skid buffer. Accepts PC redirects from branch/jump resolution and stops permanently on `halt` (syscall from decode).

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/if_skid_buf.sv | 59 +++++
 rtl/if_fetch.sv | 262 ++++++++++++++++++++++++++
 tb/tb_if_fetch.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the instruction fetch stage.
//   INSTR_W / PC_W    : instruction and program-counter widths
//   PC_INC            : sequential fetch stride in bytes
//   DEFAULT_RESET_PC  : first fetch address after reset
//   fetch_state_e     : fetch FSM states
//   pc_next()         : sequential successor of a PC (wraps modulo 2^32)
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  localparam logic [PC_W-1:0] PC_INC           = 32'd4;
  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    S_REQ    = 2'd0,
    S_WAIT   = 2'd1,
    S_HALTED = 2'd2
  } fetch_state_e;

  function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {instr, pc} skid buffer behind the IF/ID register.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   push              : load push_instr/push_pc (replaces contents on push+pop)
//   pop               : release the held entry
//   flush             : discard the held entry (wins over push/pop)
//   full              : an entry is held
//   instr, pc         : held entry
module if_skid_buf
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic [PC_W-1:0]    push_pc,
  output logic               full,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc
);

  logic               full_q, full_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc_q, pc_d;

  always_comb begin
    full_d  = full_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush) begin
      full_d = 1'b0;
    end else if (push) begin
      full_d  = 1'b1;
      instr_d = push_instr;
      pc_d    = push_pc;
    end else if (pop) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      full_q  <= full_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign full  = full_q;
  assign instr = instr_q;
  assign pc    = pc_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the PC, fetches words over a req/gnt/rvalid
// handshake with one outstanding access, and feeds decode through an IF/ID
// register backed by a one-entry skid buffer. Handles redirects and halt.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   imem_req/addr/gnt/rvalid/rdata  : instruction memory handshake
//   redirect_valid, redirect_pc     : taken branch / jump target
//   id_stall                        : decode cannot accept this cycle
//   halt                            : stop fetching permanently
//   id_valid/instr/pc/pc_plus4      : IF/ID register contents
//   fetch_count                     : consumed-instruction counter
// Build option: define IF_FETCH_COUNT_EN to implement fetch_count; otherwise
// it is tied to zero and has no flops.
module if_fetch
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               id_stall,
  input  logic               halt,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc,
  output logic [PC_W-1:0]    id_pc_plus4,
  output logic [31:0]        fetch_count
);

  fetch_state_e       state_q, state_d;
  logic               run_q;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]    pend_pc_q, pend_pc_d;
  logic               pend_q, pend_d;
  logic               drop_q, drop_d;
  logic               halting_q, halting_d;
  logic               id_valid_q, id_valid_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic [PC_W-1:0]    id_pc_q, id_pc_d;
  logic [PC_W-1:0]    id_pc_plus4_q, id_pc_plus4_d;

  logic               skid_push, skid_pop, skid_flush, skid_full, skid_full_nxt;
  logic [INSTR_W-1:0] skid_instr;
  logic [PC_W-1:0]    skid_pc;

  logic consume, granted, outstanding, resp, resp_ok, redir, stopping;

  if_skid_buf u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (skid_push),
    .pop        (skid_pop),
    .flush      (skid_flush),
    .push_instr (imem_rdata),
    .push_pc    (fetch_pc_q),
    .full       (skid_full),
    .instr      (skid_instr),
    .pc         (skid_pc)
  );

  // run_q keeps imem_req low throughout reset without a combinational
  // path from rst_n.
  assign imem_req  = run_q && (state_q == S_REQ);
  assign imem_addr = pc_q;

  assign consume     = id_valid_q && !id_stall;
  assign granted     = imem_req && imem_gnt;
  // WAIT with a full skid means the response already arrived and we are
  // only waiting for decode to drain before requesting again.
  assign outstanding = (state_q == S_WAIT) && !skid_full;
  assign resp        = outstanding && imem_rvalid;
  assign resp_ok     = resp && !drop_q;
  assign redir       = redirect_valid && (state_q != S_HALTED);
  assign stopping    = halting_q || (halt && (state_q != S_HALTED));

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_pc_d    = fetch_pc_q;
    pend_pc_d     = pend_pc_q;
    pend_d        = pend_q;
    drop_d        = drop_q;
    halting_d     = halting_q;
    id_valid_d    = id_valid_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    skid_push     = 1'b0;
    skid_pop      = 1'b0;
    skid_flush    = 1'b0;
    skid_full_nxt = skid_full;

    if (stopping) begin
      // Halt: flush, then park in HALTED once nothing is in flight. A
      // request not yet granted is withdrawn.
      id_valid_d = 1'b0;
      skid_flush = 1'b1;
      drop_d     = 1'b0;
      pend_d     = 1'b0;
      if (granted || (outstanding && !imem_rvalid)) begin
        state_d   = S_WAIT;
        halting_d = 1'b1;
      end else begin
        state_d   = S_HALTED;
        halting_d = 1'b0;
      end
    end else if (redir) begin
      id_valid_d = 1'b0;
      skid_flush = 1'b1;
      case (state_q)
        S_REQ: begin
          if (granted) begin
            state_d    = S_WAIT;
            fetch_pc_d = pc_q;
            pc_d       = redirect_pc;
            drop_d     = 1'b1;
            pend_d     = 1'b0;
          end else if (imem_req) begin
            // Address must hold until granted; remember the target.
            pend_d    = 1'b1;
            pend_pc_d = redirect_pc;
            drop_d    = 1'b1;
          end else begin
            pc_d   = redirect_pc;
            pend_d = 1'b0;
            drop_d = 1'b0;
          end
        end
        S_WAIT: begin
          pc_d = redirect_pc;
          if (outstanding && !imem_rvalid) begin
            drop_d = 1'b1;
          end else begin
            // The in-flight response (if any) is dropped right now.
            state_d = S_REQ;
            drop_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end else begin
      if (consume) begin
        if (skid_full) begin
          id_valid_d    = 1'b1;
          id_instr_d    = skid_instr;
          id_pc_d       = skid_pc;
          id_pc_plus4_d = pc_next(skid_pc);
          skid_pop      = 1'b1;
          skid_push     = resp_ok;
        end else if (resp_ok) begin
          id_valid_d    = 1'b1;
          id_instr_d    = imem_rdata;
          id_pc_d       = fetch_pc_q;
          id_pc_plus4_d = pc_next(fetch_pc_q);
        end else begin
          id_valid_d = 1'b0;
        end
      end else if (!id_valid_q) begin
        if (resp_ok) begin
          id_valid_d    = 1'b1;
          id_instr_d    = imem_rdata;
          id_pc_d       = fetch_pc_q;
          id_pc_plus4_d = pc_next(fetch_pc_q);
        end
      end else begin
        skid_push = resp_ok;
      end
      skid_full_nxt = skid_push || (skid_full && !skid_pop);

      case (state_q)
        S_REQ: begin
          if (granted) begin
            state_d    = S_WAIT;
            fetch_pc_d = pc_q;
            if (pend_q) begin
              pc_d   = pend_pc_q;
              pend_d = 1'b0;
            end else begin
              pc_d = pc_next(pc_q);
            end
          end
        end
        S_WAIT: begin
          if (resp) begin
            drop_d = 1'b0;
          end
          if ((resp || !outstanding) && !skid_full_nxt) begin
            state_d = S_REQ;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_REQ;
      run_q         <= 1'b0;
      pc_q          <= RESET_PC;
      fetch_pc_q    <= '0;
      pend_pc_q     <= '0;
      pend_q        <= 1'b0;
      drop_q        <= 1'b0;
      halting_q     <= 1'b0;
      id_valid_q    <= 1'b0;
      id_instr_q    <= '0;
      id_pc_q       <= '0;
      id_pc_plus4_q <= '0;
    end else begin
      state_q       <= state_d;
      run_q         <= 1'b1;
      pc_q          <= pc_d;
      fetch_pc_q    <= fetch_pc_d;
      pend_pc_q     <= pend_pc_d;
      pend_q        <= pend_d;
      drop_q        <= drop_d;
      halting_q     <= halting_d;
      id_valid_q    <= id_valid_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
    end
  end

  assign id_valid    = id_valid_q;
  assign id_instr    = id_instr_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_plus4_q;

`ifdef IF_FETCH_COUNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q;
    if (consume && !redirect_valid) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
`else
  assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        halt;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  // Memory model controls/state
  logic        gnt_en;
  int          lat;
  logic        out_tb;
  int          cnt;
  logic [31:0] out_addr;

  if_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_stall       (id_stall),
    .halt           (halt),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    if (a == 32'h0000_3000) return 32'h2008_0005;
    return {16'hC0DE, a[15:0]};
  endfunction

  // One clock: grant decided from current imem_req, responses delivered
  // 'lat' cycles after the grant edge. Called and returns at a negedge.
  task automatic tick();
    logic        g;
    logic        rv;
    logic [31:0] a;
    imem_gnt = gnt_en && imem_req;
    g  = imem_gnt;
    a  = imem_addr;
    rv = imem_rvalid;
    @(posedge clk);
    @(negedge clk);
    imem_rvalid = 1'b0;
    if (rv) out_tb = 1'b0;
    if (g) begin
      out_tb   = 1'b1;
      out_addr = a;
      cnt      = lat;
    end
    if (out_tb && cnt > 0) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word_of(out_addr);
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; redirect_valid = 1'b0; halt = 1'b0; id_stall = 1'b0;
    gnt_en = 1'b1; lat = 1; out_tb = 1'b0; imem_rvalid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
    id_stall = 1'b0; gnt_en = 1'b1; lat = 1; out_tb = 1'b0; cnt = 0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; out_addr = '0;
    @(negedge clk);
    tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", id_valid); end
    checks++; if (id_instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want 0", id_instr); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", id_pc); end
    checks++; if (id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL rst_pc4: got %h want 0", id_pc_plus4); end
    checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL rst_cnt: got %h want 0", fetch_count); end
    rst_n = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rel_req: got %b want 1", imem_req); end
    checks++; if (imem_addr !== 32'h3000) begin errors++; $display("FAIL rel_addr: got %h want 3000", imem_addr); end
  endtask

  task automatic test_basic();
    do_reset();
    checks++; if (imem_addr !== 32'h3000) begin errors++; $display("FAIL basic_addr0: got %h want 3000", imem_addr); end
    tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL basic_wait_req: got %b want 0", imem_req); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want 0", id_valid); end
    tick();
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", id_valid); end
    checks++; if (id_instr !== 32'h2008_0005) begin errors++; $display("FAIL basic_instr: got %h want 20080005", id_instr); end
    checks++; if (id_pc !== 32'h3000) begin errors++; $display("FAIL basic_pc: got %h want 3000", id_pc); end
    checks++; if (id_pc_plus4 !== 32'h3004) begin errors++; $display("FAIL basic_pc4: got %h want 3004", id_pc_plus4); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3004) begin errors++; $display("FAIL basic_next: got req=%b addr=%h want req=1 addr=3004", imem_req, imem_addr); end
  endtask

  task automatic test_stall();
    logic req_seen;
    do_reset();
    tick(); tick();
    id_stall = 1'b1;
    req_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i >= 1 && imem_req) req_seen = 1'b1;
    end
    checks++; if (req_seen !== 1'b0) begin errors++; $display("FAIL stall_req_low: got req_seen=%b want 0", req_seen); end
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h3000) begin errors++; $display("FAIL stall_hold: got v=%b pc=%h want v=1 pc=3000", id_valid, id_pc); end
    id_stall = 1'b0;
    tick();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h3004) begin errors++; $display("FAIL stall_skid_pc: got v=%b pc=%h want v=1 pc=3004", id_valid, id_pc); end
    checks++; if (id_instr !== 32'hC0DE_3004) begin errors++; $display("FAIL stall_skid_instr: got %h want c0de3004", id_instr); end
    checks++; if (id_pc_plus4 !== 32'h3008) begin errors++; $display("FAIL stall_skid_pc4: got %h want 3008", id_pc_plus4); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3008) begin errors++; $display("FAIL stall_resume: got req=%b addr=%h want req=1 addr=3008", imem_req, imem_addr); end
    tick();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL stall_no_dup: got %b want 0", id_valid); end
    tick();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h3008) begin errors++; $display("FAIL stall_next: got v=%b pc=%h want v=1 pc=3008", id_valid, id_pc); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    lat = 3;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h3100;
    tick();
    redirect_valid = 1'b0;
    checks++; if (id_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL rw_wait: got v=%b req=%b want v=0 req=0", id_valid, imem_req); end
    tick(); tick();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rw_dropped: got %b want 0", id_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3100) begin errors++; $display("FAIL rw_addr: got req=%b addr=%h want req=1 addr=3100", imem_req, imem_addr); end
    lat = 1;
    tick(); tick();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h3100 || id_instr !== 32'hC0DE_3100) begin errors++; $display("FAIL rw_target: got v=%b pc=%h i=%h want v=1 pc=3100 i=c0de3100", id_valid, id_pc, id_instr); end
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h3200;
    tick();
    redirect_valid = 1'b0;
    checks++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h3200) begin errors++; $display("FAIL rw_same_cycle: got v=%b req=%b addr=%h want v=0 req=1 addr=3200", id_valid, imem_req, imem_addr); end
    tick(); tick();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h3200) begin errors++; $display("FAIL rw_same_target: got v=%b pc=%h want v=1 pc=3200", id_valid, id_pc); end
  endtask

  task automatic test_redirect_nogrant();
    do_reset();
    tick(); tick(); tick(); tick();
    gnt_en = 1'b0;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3008) begin errors++; $display("FAIL rn_pre: got req=%b addr=%h want req=1 addr=3008", imem_req, imem_addr); end
    redirect_valid = 1'b1; redirect_pc = 32'h3100;
    tick();
    redirect_valid = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3008 || id_valid !== 1'b0) begin errors++; $display("FAIL rn_stable1: got req=%b addr=%h v=%b want req=1 addr=3008 v=0", imem_req, imem_addr, id_valid); end
    tick();
    checks++; if (imem_addr !== 32'h3008) begin errors++; $display("FAIL rn_stable2: got %h want 3008", imem_addr); end
    gnt_en = 1'b1;
    tick(); tick();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rn_dropped: got %b want 0", id_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3100) begin errors++; $display("FAIL rn_addr: got req=%b addr=%h want req=1 addr=3100", imem_req, imem_addr); end
    tick(); tick();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h3100 || id_instr !== 32'hC0DE_3100) begin errors++; $display("FAIL rn_target: got v=%b pc=%h i=%h want v=1 pc=3100 i=c0de3100", id_valid, id_pc, id_instr); end
  endtask

  task automatic test_halt();
    logic req_seen, vld_seen;
    do_reset();
    tick(); tick();
    id_stall = 1'b1; lat = 3;
    tick();
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL halt_pre_valid: got %b want 1", id_valid); end
    halt = 1'b1;
    tick();
    halt = 1'b0;
    checks++; if (id_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL halt_flush: got v=%b req=%b want v=0 req=0", id_valid, imem_req); end
    tick(); tick();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL halt_resp_discard: got %b want 0", id_valid); end
    id_stall = 1'b0; lat = 1;
    req_seen = 1'b0; vld_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      redirect_valid = (i == 3); redirect_pc = 32'h3100;
      tick();
      if (imem_req) req_seen = 1'b1;
      if (id_valid) vld_seen = 1'b1;
    end
    redirect_valid = 1'b0;
    checks++; if (req_seen !== 1'b0) begin errors++; $display("FAIL halt_no_req: got %b want 0", req_seen); end
    checks++; if (vld_seen !== 1'b0) begin errors++; $display("FAIL halt_no_valid: got %b want 0", vld_seen); end
    do_reset();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin errors++; $display("FAIL halt_reset_exit: got req=%b addr=%h want req=1 addr=3000", imem_req, imem_addr); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    lat = 2;
    tick();
    #1 rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || id_valid !== 1'b0) begin errors++; $display("FAIL mid_rst: got req=%b v=%b want 0 0", imem_req, id_valid); end
    rst_n = 1'b1;
    gnt_en = 1'b0;
    tick(); tick();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL mid_stale_rvalid: got %b want 0", id_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin errors++; $display("FAIL mid_restart: got req=%b addr=%h want req=1 addr=3000", imem_req, imem_addr); end
    gnt_en = 1'b1;
  endtask

  task automatic test_count();
    logic [31:0] exp_cnt;
`ifdef IF_FETCH_COUNT_EN
    exp_cnt = 32'd10;
`else
    exp_cnt = 32'd0;
`endif
    do_reset();
    for (int i = 0; i < 21; i++) tick();
    checks++; if (fetch_count !== exp_cnt) begin errors++; $display("FAIL count_10: got %0d want %0d", fetch_count, exp_cnt); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL count_gap: got %b want 0", id_valid); end
    tick();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h3028) begin errors++; $display("FAIL count_seq: got v=%b pc=%h want v=1 pc=3028", id_valid, id_pc); end
    checks++; if (fetch_count !== exp_cnt) begin errors++; $display("FAIL count_hold: got %0d want %0d", fetch_count, exp_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_redirect_nogrant();
    test_halt();
    test_reset_mid();
    test_count();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
